// File: rtl/fft_pkg.sv
// Shared types and constants for the 16-point FFT ping-pong bank scheduler.
package fft_pkg;

  localparam int N_PTS  = 16;
  localparam int ADDR_W = 4;

  typedef enum logic [2:0] {
    FREE,
    LOADING,
    FULL,
    COMPUTING,
    DONE,
    UNLOADING
  } bank_state_e;

  function automatic logic [ADDR_W-1:0] bit_rev(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) begin
      r[i] = a[ADDR_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bank_fsm.sv
// Lifecycle state of one sample bank; events come from the scheduler already qualified for this bank.
module fft_bank_fsm
  import fft_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_first,
  input  logic        ld_done,
  input  logic        start,
  input  logic        done,
  input  logic        unload_first,
  input  logic        unload_last,
  output bank_state_e state
);

  bank_state_e state_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FREE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      FREE:      if (ld_first)     state_d = LOADING;
      LOADING:   if (ld_done)      state_d = FULL;
      FULL:      if (start)        state_d = COMPUTING;
      COMPUTING: if (done)         state_d = DONE;
      DONE:      if (unload_first) state_d = UNLOADING;
      UNLOADING: if (unload_last)  state_d = FREE;
      default:                     state_d = FREE;
    endcase
  end

endmodule

// File: rtl/fft_bank_sched.sv
// Ping-pong frame scheduler: two banks shared by loader, butterfly engine and unloader, frames in order.
// Build option FFT_BITREV_LOAD_EN: loader writes samples at bit-reversed addresses.
module fft_bank_sched
  import fft_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_push,
  output logic              in_stall,
  output logic              ld_en_F,
  output logic              ld_bank_F,
  output logic [ADDR_W-1:0] ld_addr_F,
  output logic              eng_start_F,
  output logic              eng_bank_F,
  input  logic              eng_done,
  output logic              rd_en_F,
  output logic              rd_bank_F,
  output logic [ADDR_W-1:0] rd_addr_F,
  output logic              out_push_F,
  input  logic              out_stall,
  output logic              err_F
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_PTS - 1);

  bank_state_e       bank_st [2];
  bank_state_e       ld_st, eng_st, rd_st;
  logic              ld_ptr, eng_ptr, rd_ptr;
  logic              eng_busy;
  logic [ADDR_W-1:0] ld_cnt, rd_idx, ld_addr_nxt;
  logic              ld_acc, ld_last, eng_go, eng_fin, rd_go, rd_last;
  logic [RD_LAT-1:0] out_vld_p;

  assign ld_st  = bank_st[ld_ptr];
  assign eng_st = bank_st[eng_ptr];
  assign rd_st  = bank_st[rd_ptr];

  assign in_stall = !((ld_st == FREE) || (ld_st == LOADING));
  assign ld_acc   = in_push && !in_stall;
  assign ld_last  = ld_acc && (ld_cnt == LAST_IDX);
  // Busy gating keeps a start from landing in the same cycle as the done that frees the engine.
  assign eng_go   = !eng_busy && (eng_st == FULL);
  assign eng_fin  = eng_done && eng_busy;
  assign rd_go    = ((rd_st == DONE) || (rd_st == UNLOADING)) && !out_stall;
  assign rd_last  = rd_go && (rd_idx == LAST_IDX);

`ifdef FFT_BITREV_LOAD_EN
  assign ld_addr_nxt = bit_rev(ld_cnt);
`else
  assign ld_addr_nxt = ld_cnt;
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    localparam logic SEL = 1'(b);
    fft_bank_fsm u_fsm (
      .clk          (clk),
      .reset        (reset),
      .ld_first     (ld_acc && (ld_ptr == SEL) && (ld_cnt == '0)),
      .ld_done      (ld_last && (ld_ptr == SEL)),
      .start        (eng_go && (eng_ptr == SEL)),
      .done         (eng_fin && (eng_ptr == SEL)),
      .unload_first (rd_go && (rd_ptr == SEL) && (rd_idx == '0)),
      .unload_last  (rd_last && (rd_ptr == SEL)),
      .state        (bank_st[b])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ld_ptr      <= 1'b0;
      eng_ptr     <= 1'b0;
      rd_ptr      <= 1'b0;
      eng_busy    <= 1'b0;
      ld_cnt      <= '0;
      rd_idx      <= '0;
      ld_en_F     <= 1'b0;
      ld_bank_F   <= 1'b0;
      ld_addr_F   <= '0;
      eng_start_F <= 1'b0;
      eng_bank_F  <= 1'b0;
      rd_en_F     <= 1'b0;
      rd_bank_F   <= 1'b0;
      rd_addr_F   <= '0;
      err_F       <= 1'b0;
    end else begin
      ld_en_F <= ld_acc;
      if (ld_acc) begin
        ld_bank_F <= ld_ptr;
        ld_addr_F <= ld_addr_nxt;
        ld_cnt    <= ld_cnt + 1'b1;
        if (ld_last) ld_ptr <= ~ld_ptr;
      end

      eng_start_F <= eng_go;
      if (eng_go) begin
        eng_busy   <= 1'b1;
        eng_bank_F <= eng_ptr;
      end
      if (eng_fin) begin
        eng_busy <= 1'b0;
        eng_ptr  <= ~eng_ptr;
      end
      if (eng_done && !eng_busy) err_F <= 1'b1;

      rd_en_F <= rd_go;
      if (rd_go) begin
        rd_bank_F <= rd_ptr;
        rd_addr_F <= rd_idx;
        rd_idx    <= rd_idx + 1'b1;
        if (rd_last) rd_ptr <= ~rd_ptr;
      end
    end
  end

  // Read-latency pipe: stage p0 aligns with memory data one cycle after rd_en_F.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_vld_p <= '0;
    end else begin
      out_vld_p[0] <= rd_en_F;
      for (int i = 1; i < RD_LAT; i++) begin
        out_vld_p[i] <= out_vld_p[i-1];
      end
    end
  end

  assign out_push_F = out_vld_p[RD_LAT-1];

endmodule
